// File: rtl/dct_quant_zigzag.sv
// Quantizes an 8x8 DCT block with per-position reciprocals and streams it
// out in JPEG zig-zag order, one coefficient per accepted beat.
module dct_quant_zigzag #(
   parameter int unsigned IN_W    = 32,
   parameter int unsigned FRAC    = 8,
   parameter int unsigned OUT_W   = 16,
   parameter int unsigned RECIP_W = 17
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [64*IN_W-1:0]     in_data,
   input  logic [64*RECIP_W-1:0]  q_recip,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic [5:0]             out_index,
   output logic                   out_last
);

   localparam int unsigned PW = IN_W + RECIP_W + 1;
   localparam int unsigned S  = 16 + FRAC;

   localparam logic [PW-1:0] HALF   = PW'(1) << (S - 1);
   localparam logic [PW-1:0] MAXPOS = (PW'(1) << (OUT_W - 1)) - PW'(1);
   localparam logic [PW-1:0] MAXNEG = PW'(1) << (OUT_W - 1);

   typedef logic [63:0][5:0] zz_t;

   // Walk the anti-diagonals: odd d with row rising, even d with row falling.
   function automatic zz_t zz_table();
      zz_t t;
      int  n;
      int  r;
      int  c;
      t = '0;
      n = 0;
      for (int d = 0; d < 15; d++) begin
         for (int i = 0; i < 8; i++) begin
            r = (d % 2 == 1) ? i : 7 - i;
            c = d - r;
            if (c >= 0 && c < 8) begin
               t[n] = 6'(r * 8 + c);
               n++;
            end
         end
      end
      return t;
   endfunction

   localparam zz_t ZZ = zz_table();

   typedef enum logic [1:0] {StIdle, StFill, StSerial} state_e;

   state_e                        r_state;
   state_e                        w_state_next;
   logic [63:0][IN_W-1:0]         r_blk;
   logic [63:0][RECIP_W-1:0]      r_recip;
   logic [5:0]                    r_k;
   logic [OUT_W-1:0]              r_out;

   logic                          w_hs;
   logic [5:0]                    w_sel;
   logic [5:0]                    w_pos;
   logic signed [IN_W-1:0]        w_coef;
   logic [RECIP_W-1:0]            w_rec;
   logic signed [PW-1:0]          w_prod;
   logic                          w_neg;
   logic [PW-1:0]                 w_mag;
   logic [PW-1:0]                 w_rnd;
   logic [OUT_W-1:0]              w_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_next;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = StFill;
         end
         StFill: w_state_next = StSerial;
         StSerial: begin
            out_valid = 1'b1;
            if (out_ready && r_k == 6'd63) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   assign w_hs = in_valid && in_ready;

   // In FILL the first coefficient is prepared; in SERIAL the next one is.
   assign w_sel  = (r_state == StSerial) ? r_k + 6'd1 : r_k;
   assign w_pos  = ZZ[w_sel];
   assign w_coef = r_blk[w_pos];
   assign w_rec  = r_recip[w_pos];
   assign w_prod = PW'(w_coef) * PW'($signed({1'b0, w_rec}));
   assign w_neg  = w_prod[PW-1];
   assign w_mag  = w_neg ? -w_prod : w_prod;
   assign w_rnd  = (w_mag + HALF) >> S;

   // Round half away from zero, then saturate to the signed output range
   always_comb begin
      w_q = '0;
      if (!w_neg) begin
         w_q = (w_rnd > MAXPOS) ? {1'b0, {(OUT_W-1){1'b1}}} : w_rnd[OUT_W-1:0];
      end else begin
         w_q = (w_rnd > MAXNEG) ? {1'b1, {(OUT_W-1){1'b0}}} : -w_rnd[OUT_W-1:0];
      end
   end

   // Capture block and reciprocals; later input changes cannot reach the block in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk   <= '0;
         r_recip <= '0;
      end else if (w_hs) begin
         r_blk   <= in_data;
         r_recip <= q_recip;
      end
   end

   // Beat index and registered quantized output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k   <= '0;
         r_out <= '0;
      end else if (w_hs) begin
         r_k <= '0;
      end else if (r_state == StFill) begin
         r_out <= w_q;
      end else if (r_state == StSerial && out_ready) begin
         if (r_k != 6'd63) begin
            r_out <= w_q;
            r_k   <= r_k + 6'd1;
         end else begin
            r_k <= '0;
         end
      end
   end

   assign out_data  = r_out;
   assign out_index = r_k;
   assign out_last  = (r_state == StSerial) && (r_k == 6'd63);

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: order, rounding, saturation,
// backpressure and asynchronous reset in mid-block.
module tb_dct_quant_zigzag;

   localparam int IN_W    = 32;
   localparam int FRAC    = 8;
   localparam int OUT_W   = 16;
   localparam int RECIP_W = 17;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [64*IN_W-1:0]    in_data = '0;
   logic [64*RECIP_W-1:0] q_recip = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [OUT_W-1:0]      out_data;
   logic [5:0]            out_index;
   logic                  out_last;

   dct_quant_zigzag #(
      .IN_W    (IN_W),
      .FRAC    (FRAC),
      .OUT_W   (OUT_W),
      .RECIP_W (RECIP_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .q_recip   (q_recip),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Standard JPEG zig-zag scan (scan index -> row-major position)
   int zz[64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                  12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                  35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                  58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

   int          coef[64];
   int unsigned rec[64];
   longint      exp_q[64];

   task automatic check(input string tag, input longint got, input longint want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // Reference: round half away from zero on coef*recip / 2^24, then clamp
   function automatic longint quant(input int c, input int unsigned r);
      longint m;
      longint mag;
      longint q;
      m   = longint'(c) * longint'(r);
      mag = (m < 0) ? -m : m;
      q   = (mag + 64'sd8388608) >>> 24;
      if (m < 0) q = -q;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   task automatic compute_exp();
      for (int k = 0; k < 64; k++) exp_q[k] = quant(coef[zz[k]], rec[zz[k]]);
   endtask

   task automatic set_uniform();
      for (int p = 0; p < 64; p++) begin
         coef[p]  = 0;
         rec[p]   = 65536;
         exp_q[p] = 0;
      end
   endtask

   task automatic set_random();
      for (int p = 0; p < 64; p++) begin
         coef[p] = int'($urandom_range(0, 33554431)) - 16777216;
         rec[p]  = $urandom_range(1, 65536);
      end
   endtask

   task automatic load_inputs();
      for (int p = 0; p < 64; p++) begin
         in_data[p*IN_W +: IN_W]       = coef[p];
         q_recip[p*RECIP_W +: RECIP_W] = rec[p][RECIP_W-1:0];
      end
   endtask

   // Called at #1 after an edge with the DUT idle; returns at the first beat (N+2).
   task automatic start_block(input bit hold);
      load_inputs();
      in_valid = 1'b1;
      check("idle_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = hold;
      check("fill_in_ready", in_ready, 0);
      check("fill_out_valid", out_valid, 0);
      @(posedge clk); #1;
   endtask

   task automatic collect(input bit rnd, input int stop);
      int               b = 0;
      int               cyc = 0;
      bit               stalled = 0;
      logic [OUT_W-1:0] s_data = '0;
      logic [5:0]       s_idx = '0;
      logic             s_last = 1'b0;
      while (b < stop && cyc < 2000) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         check("beat_out_valid", out_valid, 1);
         check("busy_in_ready", in_ready, 0);
         if (stalled) begin
            check("stall_data", out_data, s_data);
            check("stall_index", out_index, s_idx);
            check("stall_last", out_last, s_last);
         end
         if (out_ready) begin
            check("beat_data", longint'($signed(out_data)), exp_q[b]);
            check("beat_index", out_index, b);
            check("beat_last", out_last, (b == 63) ? 1 : 0);
            b++;
            stalled = 0;
         end else begin
            stalled = 1;
            s_data  = out_data;
            s_idx   = out_index;
            s_last  = out_last;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 2000) check("beat_timeout", b, stop);
      out_ready = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #23;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_index", out_index, 0);
      check("rst_in_ready", in_ready, 1);
      #7 rst_n = 1'b1;
      @(posedge clk); #1;

      // All-zero block, Q=1
      set_uniform();
      start_block(0);
      collect(0, 64);
      check_idle("zero_end");

      // Coefficient p quantizes to p, so beats reveal the scan order
      set_uniform();
      for (int p = 0; p < 64; p++) coef[p] = p << FRAC;
      for (int k = 0; k < 64; k++) exp_q[k] = zz[k];
      start_block(0);
      collect(0, 64);
      check_idle("order_end");

      // DC only: 1024 / 16 = 64
      set_uniform();
      coef[0]  = 1024 << FRAC;
      rec[0]   = 4096;
      exp_q[0] = 64;
      start_block(0);
      collect(0, 64);
      check_idle("dc_end");

      // Rounding and saturation at scan positions 0..5 (row-major 0,1,8,16,9,2)
      set_uniform();
      coef[0]  = 384;            exp_q[0] = 2;
      coef[1]  = -384;           exp_q[1] = -2;
      coef[8]  = 320;            exp_q[2] = 1;
      coef[16] = 40000 << FRAC;  exp_q[3] = 32767;
      coef[9]  = -(40000 << FRAC); exp_q[4] = -32768;
      coef[2]  = -320;           exp_q[5] = -1;
      start_block(0);
      collect(0, 64);
      check_idle("round_end");

      // Backpressure; next block held valid and changed under the block in flight
      set_random();
      compute_exp();
      start_block(1);
      set_random();
      load_inputs();
      collect(1, 64);
      check_idle("bp_end");
      compute_exp();
      @(posedge clk); #1;
      check("bp_second_accept", in_ready, 0);
      check("bp_second_fill_valid", out_valid, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      collect(1, 64);
      check_idle("bp2_end");

      // Reset after beat 20
      set_random();
      compute_exp();
      start_block(0);
      collect(1, 21);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_index", out_index, 0);
      check("midrst_out_last", out_last, 0);
      check("midrst_out_data", out_data, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("postrst");
      set_random();
      compute_exp();
      start_block(0);
      collect(1, 64);
      check_idle("postrst_end");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dct_quant_zigzag.md
# dct_quant_zigzag

Quantizes one 8×8 block of 2-D DCT coefficients and serializes it in JPEG zig-zag order, one coefficient per cycle. It sits directly downstream of the parallel 8×8 DCT stage and takes that stage's flattened 64-coefficient output word over a valid/ready handshake. It feeds the run-length/entropy coding stage. Quantization uses per-position reciprocals so that no divider is needed.

## Interface
Parameters:
- IN_W, 32: width of each signed input coefficient; matches the DCT stage.
- FRAC, 8: fractional bits of the input coefficients.
- OUT_W, 16: width of each signed quantized output coefficient.
- RECIP_W, 17: width of each unsigned reciprocal entry.

Ports:
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a valid block.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  64*IN_W  row-major coefficients; element r*8+c sits at bits [(r*8+c)*IN_W +: IN_W].
- q_recip  in  64*RECIP_W  row-major reciprocals, recip[k] = round(65536/Q[k]); sampled together with in_data.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  downstream accepts the current beat.
- out_data  out  OUT_W  quantized coefficient.
- out_index  out  6  zig-zag position of the beat (0..63).
- out_last  out  1  high on the beat where out_index==63.

## Operation
- Three states: IDLE, FILL, SERIAL.
- in_ready is 1 only in IDLE.
- On an input handshake:
  - in_data is latched into the block register and q_recip into the reciprocal register.
  - Index counter k is cleared to 0.
  - The state moves IDLE→FILL.
- FILL lasts exactly one cycle. It loads the output register with quant(zz[0]), then moves to SERIAL.
- SERIAL:
  - out_valid is 1.
  - When out_ready && k<63: the output register loads quant(zz[k+1]) and k increments.
  - When out_ready && k==63: the state moves to IDLE and out_valid falls.
- When out_ready is 0, out_data, out_index, out_last and k hold.
- Zig-zag map zz[k] → row-major position. Traverse anti-diagonals d=r+c from 0 to 14:
  - Odd d: visit with r increasing.
  - Even d: visit with r decreasing.
  - Resulting sequence: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,… ending …,55,62,63.
- Arithmetic quant(p):
  - Product m = coef[p] (signed, IN_W bits) × recip[p] (zero-extended): a signed IN_W+RECIP_W+1-bit result.
  - Shift S = 16+FRAC.
  - q = sign(m) × ((|m| + 2^(S-1)) >> S), i.e. round half away from zero.
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- The multiply-round-saturate path is a single registered stage: the zig-zag mux feeds the multiplier, which feeds the output register.
- in_valid while not in IDLE is ignored; the block stays pending upstream.
- Changes to in_data or q_recip after capture have no effect on the block in flight.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, k=0
  - out_valid=0, out_last=0, out_data=0, out_index=0
  - in_ready=1
- A reset asserted mid-block aborts it immediately. No partial beats follow, and the next block starts clean.
- Latency: input handshake in cycle N → FILL in N+1 → first beat (out_valid=1, out_index=0) in N+2.
- Full-rate output: beats in cycles N+2..N+65, state IDLE in N+66, next handshake possible in N+66. Minimum block period is 66 cycles.
- With stalls, every cycle where out_valid && !out_ready extends the block by one cycle. No beat is dropped or duplicated.
- out_last coincides with out_index==63 only.

## Test plan
- **All-zero block, recip all 65536 (Q=1):** 64 beats, out_data=0, out_index 0..63 in order, out_last only on beat 63, in_ready low from N+1 to N+65.
- **Zig-zag order:** coef[p]=p<<FRAC, recip all 65536 → out_data sequence 0,1,8,16,9,2,3,10,17,24,…,55,62,63.
- **DC quantization:** coef[0]=1024<<8, recip[0]=4096 (Q=16), all other coefficients 0 → first beat 64, all others 0.
- **Rounding and saturation** (Q=1):
  - +1.5 (384) → 2
  - −1.5 (−384) → −2
  - +1.25 (320) → 1
  - 40000<<8 → 32767
  - −40000<<8 → −32768
- **Backpressure:** out_ready random at 50%, second block presented with in_valid held throughout:
  - Outputs are stable while stalled and bit-exact against the model.
  - The second block is accepted exactly in the cycle after the final out_last handshake.
- **Reset mid-block:** assert rst_n=0 after beat 20 → out_valid=0 and in_ready=1 asynchronously. After release, a fresh block yields the full 64 correct beats.
